// File: rtl/tdm_pkg.sv
// Shared types and constants for the two-slot TDM demultiplexer.
package tdm_pkg;

    localparam int W_DEF = 4;
    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SLOT_A,
        SLOT_B
    } state_t;

endpackage

// File: rtl/tdm_shift.sv
// MSB-first serial-in shift register with clear and enable.
// nxt_o exposes the next-state value so a word can be captured on its last bit.
module tdm_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         d_i,
    output logic [W-1:0] nxt_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = {sr_q[W-2:0], d_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign nxt_o = sr_d;

endmodule

// File: rtl/tdm_demux2.sv
// Two-slot TDM demultiplexer: frame FSM, bit counter, output words,
// valid/error pulses and a saturating framing-error counter.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sdi,
    input  logic             fsync,
    output logic [W-1:0]     a_data,
    output logic             a_valid,
    output logic [W-1:0]     b_data,
    output logic             b_valid,
    output logic             busy,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     a_data_q, a_data_d;
    logic [W-1:0]     b_data_q, b_data_d;
    logic             a_vld_q, a_vld_d;
    logic             b_vld_q, b_vld_d;
    logic             ferr_q, ferr_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             sh_en;
    logic             sh_clr;
    logic [W-1:0]     word;
    logic             last;

    tdm_shift #(
        .W(W)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (sh_en),
        .clr_i (sh_clr),
        .d_i   (sdi),
        .nxt_o (word)
    );

    assign last = (cnt_q == CW'(W - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        a_vld_d  = 1'b0;
        b_vld_d  = 1'b0;
        ferr_d   = 1'b0;
        err_d    = err_q;
        sh_en    = 1'b0;
        sh_clr   = 1'b0;
        if (ena) begin
            if (fsync) begin
                // A strobe inside a frame drops the partial word and restarts.
                if (state_q != IDLE) begin
                    ferr_d = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end
                sh_en   = 1'b1;
                cnt_d   = CW'(1);
                state_d = SLOT_A;
            end else begin
                case (state_q)
                    IDLE: begin
                        sh_clr = 1'b1;
                    end
                    SLOT_A: begin
                        sh_en = 1'b1;
                        if (last) begin
                            a_data_d = word;
                            a_vld_d  = 1'b1;
                            cnt_d    = '0;
                            state_d  = SLOT_B;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    SLOT_B: begin
                        sh_en = 1'b1;
                        if (last) begin
                            b_data_d = word;
                            b_vld_d  = 1'b1;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            ferr_q   <= 1'b0;
            err_q    <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
            a_vld_q  <= a_vld_d;
            b_vld_q  <= b_vld_d;
            ferr_q   <= ferr_d;
            err_q    <= err_d;
        end
    end

    // Pulses are held across stalls and only shown in enabled cycles.
    assign a_valid   = a_vld_q & ena;
    assign b_valid   = b_vld_q & ena;
    assign frame_err = ferr_q & ena;
    assign a_data    = a_data_q;
    assign b_data    = b_data_q;
    assign err_count = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tdm_demux2.sv
// Scoreboard bench for tdm_demux2 (W=4): expected words, valid cycles and
// framing-error cycles are queued by the stimulus and consumed by a monitor.
module tb_tdm_demux2;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         sdi;
    logic         fsync;
    logic [W-1:0] a_data;
    logic [W-1:0] b_data;
    logic         a_valid;
    logic         b_valid;
    logic         busy;
    logic         frame_err;
    logic [7:0]   err_count;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit           ch;
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t sbq[$];
    int   feq[$];
    bit   pa, pb, pf;

    tdm_demux2 #(
        .W(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .sdi       (sdi),
        .fsync     (fsync),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        int   x;
        if (!rst_n) begin
            pa = 0;
            pb = 0;
            pf = 0;
        end else begin
            if (a_valid) begin
                n_chk++;
                if (sbq.size() == 0 || sbq[0].ch) begin
                    n_fail++;
                    $display("FAIL a_pulse: unexpected a_valid cyc=%0d a_data=%h",
                             cyc, a_data);
                end else begin
                    e = sbq.pop_front();
                    if (a_data !== e.d || cyc != e.c) begin
                        n_fail++;
                        $display("FAIL a_word: got %h at cyc %0d, want %h at cyc %0d",
                                 a_data, cyc, e.d, e.c);
                    end
                end
                if (pa) begin
                    n_fail++;
                    $display("FAIL a_consec: a_valid high two cycles at cyc %0d", cyc);
                end
            end
            if (b_valid) begin
                n_chk++;
                if (sbq.size() == 0 || !sbq[0].ch) begin
                    n_fail++;
                    $display("FAIL b_pulse: unexpected b_valid cyc=%0d b_data=%h",
                             cyc, b_data);
                end else begin
                    e = sbq.pop_front();
                    if (b_data !== e.d || cyc != e.c) begin
                        n_fail++;
                        $display("FAIL b_word: got %h at cyc %0d, want %h at cyc %0d",
                                 b_data, cyc, e.d, e.c);
                    end
                end
                if (pb) begin
                    n_fail++;
                    $display("FAIL b_consec: b_valid high two cycles at cyc %0d", cyc);
                end
            end
            if (frame_err) begin
                n_chk++;
                if (feq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ferr_pulse: unexpected frame_err at cyc %0d", cyc);
                end else begin
                    x = feq.pop_front();
                    if (x != cyc) begin
                        n_fail++;
                        $display("FAIL ferr_cyc: frame_err at cyc %0d, want cyc %0d",
                                 cyc, x);
                    end
                end
                if (pf) begin
                    n_fail++;
                    $display("FAIL ferr_consec: frame_err high two cycles at cyc %0d", cyc);
                end
            end
            if (sbq.size() > 0 && sbq[0].c < cyc) begin
                n_chk++;
                n_fail++;
                e = sbq.pop_front();
                $display("FAIL missing_valid: ch %0d word %h due cyc %0d, now %0d",
                         e.ch, e.d, e.c, cyc);
            end
            if (feq.size() > 0 && feq[0] < cyc) begin
                n_chk++;
                n_fail++;
                x = feq.pop_front();
                $display("FAIL missing_ferr: frame_err due cyc %0d, now %0d", x, cyc);
            end
            pa = a_valid;
            pb = b_valid;
            pf = frame_err;
        end
    end

    task automatic tick(input logic fs, input logic d, input logic en = 1'b1);
        ena   = en;
        fsync = fs;
        sdi   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input logic fs0, input int n);
        for (int i = 0; i < n; i++) begin
            tick(fs0 && (i == 0), w[W-1-i]);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        sbq.push_back('{1'b0, a, cyc + W});
        sbq.push_back('{1'b1, b, cyc + 2 * W});
        send_bits(a, 1'b1, W);
        send_bits(b, 1'b0, W);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        n_chk++;
        if ({a_data, b_data, a_valid, b_valid, frame_err, busy, err_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: a=%h b=%h av=%b bv=%b fe=%b busy=%b ec=%0d, want all 0",
                     a_data, b_data, a_valid, b_valid, frame_err, busy, err_count);
        end
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b1);
        n_chk++;
        if (busy !== 1'b0 || a_data !== '0 || b_data !== '0) begin
            n_fail++;
            $display("FAIL idle_no_fsync: busy=%b a=%h b=%h, want 0 0 0",
                     busy, a_data, b_data);
        end
    endtask

    task automatic test_frame();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 4'hB;
        b = 4'h6;
        sbq.push_back('{1'b0, a, cyc + 4});
        sbq.push_back('{1'b1, b, cyc + 8});
        send_bits(a, 1'b1, 2);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_frame: busy=%b, want 1", busy);
        end
        for (int i = 2; i < W; i++) tick(1'b0, a[W-1-i]);
        send_bits(b, 1'b0, W);
        tick(1'b0, 1'b0);
        n_chk++;
        if (a_data !== 4'hB || b_data !== 4'h6 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_words: a=%h b=%h busy=%b, want B 6 0",
                     a_data, b_data, busy);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(4'hF, 4'h0);
        send_frame(4'h3, 4'hC);
        tick(1'b0, 1'b0);
        n_chk++;
        if (a_data !== 4'h3 || b_data !== 4'hC) begin
            n_fail++;
            $display("FAIL b2b_words: a=%h b=%h, want 3 C", a_data, b_data);
        end
    endtask

    task automatic test_frame_error();
        logic [W-1:0] w;
        int t0;
        send_frame(4'h5, 4'h9);
        tick(1'b0, 1'b0);
        sbq.push_back('{1'b0, 4'hA, cyc + 4});
        send_bits(4'hA, 1'b1, W);
        send_bits(4'hE, 1'b0, 2);
        t0 = cyc;
        feq.push_back(t0 + 1);
        sbq.push_back('{1'b0, 4'h7, t0 + 4});
        sbq.push_back('{1'b1, 4'h2, t0 + 8});
        w = 4'h7;
        tick(1'b1, w[W-1]);
        n_chk++;
        if (frame_err !== 1'b1 || err_count !== 8'd1 || b_data !== 4'h9) begin
            n_fail++;
            $display("FAIL ferr_effects: fe=%b ec=%0d b=%h, want 1 1 9",
                     frame_err, err_count, b_data);
        end
        for (int i = 1; i < W; i++) tick(1'b0, w[W-1-i]);
        send_bits(4'h2, 1'b0, W);
        tick(1'b0, 1'b0);
        n_chk++;
        if (a_data !== 4'h7 || b_data !== 4'h2 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL ferr_recover: a=%h b=%h ec=%0d, want 7 2 1",
                     a_data, b_data, err_count);
        end
    endtask

    task automatic test_ena_stall();
        logic [W-1:0] w;
        w = 4'h9;
        sbq.push_back('{1'b0, w, cyc + 4 + 3});
        sbq.push_back('{1'b1, 4'h4, cyc + 8 + 3});
        send_bits(w, 1'b1, 2);
        repeat (3) tick(1'b1, 1'($urandom), 1'b0);
        n_chk++;
        if (busy !== 1'b1 || err_count !== 8'd1 || a_data !== 4'h7) begin
            n_fail++;
            $display("FAIL stall_hold: busy=%b ec=%0d a=%h, want 1 1 7",
                     busy, err_count, a_data);
        end
        for (int i = 2; i < W; i++) tick(1'b0, w[W-1-i]);
        send_bits(4'h4, 1'b0, W);
        tick(1'b0, 1'b0);
        n_chk++;
        if (a_data !== 4'h9 || b_data !== 4'h4) begin
            n_fail++;
            $display("FAIL stall_words: a=%h b=%h, want 9 4", a_data, b_data);
        end
    endtask

    task automatic test_saturation();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 260; i++) begin
            feq.push_back(cyc + 1);
            tick(1'b1, 1'($urandom));
            tick(1'b0, 1'($urandom));
            if (i == 100) begin
                n_chk++;
                if (err_count !== 8'd102) begin
                    n_fail++;
                    $display("FAIL err_count_mid: got %0d, want 102", err_count);
                end
            end
        end
        n_chk++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL err_count_sat: got %0d, want 255", err_count);
        end
    endtask

    task automatic test_reset_midframe();
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_rst: busy=%b, want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({a_data, b_data, a_valid, b_valid, frame_err, busy, err_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: a=%h b=%h av=%b bv=%b fe=%b busy=%b ec=%0d, want all 0",
                     a_data, b_data, a_valid, b_valid, frame_err, busy, err_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) tick(1'b0, 1'($urandom));
        n_chk++;
        if (busy !== 1'b0 || a_data !== '0 || b_data !== '0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL post_rst_idle: busy=%b a=%h b=%h ec=%0d, want 0 0 0 0",
                     busy, a_data, b_data, err_count);
        end
        send_frame(4'hC, 4'h5);
        tick(1'b0, 1'b0);
        n_chk++;
        if (a_data !== 4'hC || b_data !== 4'h5) begin
            n_fail++;
            $display("FAIL post_rst_frame: a=%h b=%h, want C 5", a_data, b_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        fsync = 1'b0;
        sdi   = 1'b0;
        test_reset();
        test_frame();
        test_back_to_back();
        test_frame_error();
        test_ena_stall();
        test_saturation();
        test_reset_midframe();
        repeat (3) tick(1'b0, 1'b0);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected words never seen, want 0", sbq.size());
        end
        n_chk++;
        if (feq.size() != 0) begin
            n_fail++;
            $display("FAIL ferr_drain: %0d expected errors never seen, want 0", feq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
